spi2mem_slave: RTL and testbench

- SPI slave (mode 0, MSB first) that receives a WIDTH-bit MOSI frame, e.g. a relay drive word, and commits it to a parallel output register in the system clock domain.
- Commit happens only on a valid frame: exactly WIDTH bits between cs_n fall and rise.
- Sits alongside the MISO readback slave on the same spi_clk/cs_n bus: that slave returns the status word, this block consumes the command word and feeds the relay driver logic.

---
 rtl/spi2mem_slave.sv | 138 +++++++++++++
 tb/tb_spi2mem_slave.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi2mem_slave.sv
// SPI mode-0 slave: shifts a WIDTH-bit MOSI frame and commits it to a clk-domain register on a valid cs_n rise.
// Optional SPI2MEM_CRC8_EN appends a CRC-8 (poly 0x07) check to the frame; update/frame_err 4 clk edges after cs_n rise.
module spi2mem_slave #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_clk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic [WIDTH-1:0] memory,
    output logic             update,
    output logic             frame_err,
    output logic [7:0]       err_count
);

`ifdef SPI2MEM_CRC8_EN
    localparam int FLEN = WIDTH + 8;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FLEN);
    localparam logic [CW-1:0] CNT_OVR  = CW'(FLEN + 1);

    // SPI domain state
    logic [FLEN-1:0] shift_q;
    logic [CW-1:0]   cnt_q;
    logic            fresh_q;
    logic            crc_ok;

    // clk domain state
    logic             cs_meta_q, cs_sync_q, cs_prev_q, rise_q;
    logic             fr_meta_q, fr_sync_q, armed_q;
    logic [WIDTH-1:0] memory_q;
    logic             update_q, frame_err_q;
    logic [7:0]       err_count_q;
    logic             frame_ok;

    // fresh is held set while cs_n is high, so the first bit of every frame restarts the count
    always_ff @(posedge spi_clk or posedge reset or posedge cs_n) begin
        if (reset) begin
            fresh_q <= 1'b1;
        end else if (cs_n) begin
            fresh_q <= 1'b1;
        end else begin
            fresh_q <= 1'b0;
        end
    end

    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (!cs_n) begin
            shift_q <= {shift_q[FLEN-2:0], mosi};
            if (fresh_q) begin
                cnt_q <= CW'(1);
            end else if (cnt_q != CNT_OVR) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

`ifdef SPI2MEM_CRC8_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    // only the first WIDTH bits of a frame feed the CRC; the trailing byte is the received CRC
    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            crc_q <= 8'h00;
        end else if (!cs_n) begin
            if (fresh_q) begin
                crc_q <= crc_step(8'h00, mosi);
            end else if (cnt_q < CW'(WIDTH)) begin
                crc_q <= crc_step(crc_q, mosi);
            end
        end
    end

    assign crc_ok = (crc_q == shift_q[7:0]);
`else
    assign crc_ok = 1'b1;
`endif

    // shift/count are quiescent by the time rise_q fires, so they are read directly
    assign frame_ok = armed_q && (cnt_q == CNT_FULL) && crc_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            rise_q      <= 1'b0;
            fr_meta_q   <= 1'b1;
            fr_sync_q   <= 1'b1;
            armed_q     <= 1'b0;
            memory_q    <= '0;
            update_q    <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            cs_meta_q   <= cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            rise_q      <= cs_sync_q & ~cs_prev_q;
            fr_meta_q   <= fresh_q;
            fr_sync_q   <= fr_meta_q;
            update_q    <= 1'b0;
            frame_err_q <= 1'b0;
            if (rise_q) begin
                armed_q <= 1'b0;
                if (frame_ok) begin
                    memory_q <= shift_q[FLEN-1 -: WIDTH];
                    update_q <= 1'b1;
                end else begin
                    frame_err_q <= 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                end
            end else if (!fr_sync_q) begin
                // at least one SPI bit has arrived since the last decision
                armed_q <= 1'b1;
            end
        end
    end

    assign memory    = memory_q;
    assign update    = update_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_spi2mem_slave.sv
// Directed bench for spi2mem_slave: valid/short/long/empty frames, mid-frame reset, err_count saturation, optional CRC.
`timescale 1ns/1ps
module tb_spi2mem_slave;
    localparam int WIDTH = 48;
`ifdef SPI2MEM_CRC8_EN
    localparam int FLEN = WIDTH + 8;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             spi_clk = 1'b0;
    logic             cs_n = 1'b1;
    logic             mosi = 1'b0;
    logic [WIDTH-1:0] memory;
    logic             update;
    logic             frame_err;
    logic [7:0]       err_count;

    int checks = 0;
    int errors = 0;
    int n_upd, n_ferr, upd_lat;

    spi2mem_slave #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .memory    (memory),
        .update    (update),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] crc8_model(input logic [WIDTH-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic shift_bits(input logic [63:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            #50 spi_clk = 1'b1;
            #50 spi_clk = 1'b0;
        end
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        #50;
    endtask

    // Raises cs_n just after a clk edge and watches 10 clk cycles for the outcome pulses.
    task automatic end_frame();
        #50;
        @(posedge clk);
        #1 cs_n = 1'b1;
        n_upd = 0;
        n_ferr = 0;
        upd_lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (update) begin
                n_upd++;
                if (upd_lat == 0) upd_lat = c;
            end
            if (frame_err) n_ferr++;
        end
    endtask

    task automatic send_data(input logic [WIDTH-1:0] d);
        logic [63:0] v;
        start_frame();
`ifdef SPI2MEM_CRC8_EN
        v = {8'h00, d, crc8_model(d)};
`else
        v = {16'h0000, d};
`endif
        shift_bits(v, FLEN);
        end_frame();
    endtask

    task automatic send_bits(input logic [63:0] d, input int n);
        start_frame();
        shift_bits(d, n);
        end_frame();
    endtask

    task automatic test_reset();
        #35;
        checks++; if (memory !== '0) begin errors++; $display("FAIL reset_memory: got %h want 0", memory); end
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b want 0", update); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_valid_frame();
        send_data(48'h01AA55000F43);
        checks++; if (memory !== 48'h01AA55000F43) begin errors++; $display("FAIL valid_memory: got %h want 01aa55000f43", memory); end
        checks++; if (n_upd != 1) begin errors++; $display("FAIL valid_update_count: got %0d want 1", n_upd); end
        checks++; if (upd_lat != 4) begin errors++; $display("FAIL valid_latency: got %0d want 4", upd_lat); end
        checks++; if (n_ferr != 0) begin errors++; $display("FAIL valid_frame_err: got %0d want 0", n_ferr); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL valid_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_short_long();
        send_bits(64'h0000_1234_5678_9ABC, FLEN - 1);
        checks++; if (memory !== 48'h01AA55000F43) begin errors++; $display("FAIL short_memory: got %h want 01aa55000f43", memory); end
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL short_frame_err: got %0d want 1", n_ferr); end
        checks++; if (n_upd != 0) begin errors++; $display("FAIL short_update: got %0d want 0", n_upd); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL short_err_count: got %0d want 1", err_count); end
        send_bits(64'h0000_FEDC_BA98_7654, FLEN + 1);
        checks++; if (memory !== 48'h01AA55000F43) begin errors++; $display("FAIL long_memory: got %h want 01aa55000f43", memory); end
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL long_frame_err: got %0d want 1", n_ferr); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL long_err_count: got %0d want 2", err_count); end
    endtask

    task automatic test_no_clock();
        start_frame();
        end_frame();
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL noclk_frame_err: got %0d want 1", n_ferr); end
        checks++; if (n_upd != 0) begin errors++; $display("FAIL noclk_update: got %0d want 0", n_upd); end
        checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL noclk_err_count: got %0d want 3", err_count); end
    endtask

    task automatic test_midframe_reset();
        start_frame();
        shift_bits(64'hFFFFF, 20);
        #30 reset = 1'b1;
        #100 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (memory !== '0) begin errors++; $display("FAIL midreset_memory_cleared: got %h want 0", memory); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL midreset_err_cleared: got %0d want 0", err_count); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midreset_spurious_err: got %b want 0", frame_err); end
        shift_bits(64'hFFFFFFFFFFFFFFFF, FLEN - 20);
        end_frame();
        checks++; if (memory !== '0) begin errors++; $display("FAIL midreset_memory: got %h want 0", memory); end
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL midreset_frame_err: got %0d want 1", n_ferr); end
        checks++; if (n_upd != 0) begin errors++; $display("FAIL midreset_update: got %0d want 0", n_upd); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL midreset_err_count: got %0d want 1", err_count); end
        send_data(48'hFFFFFFFFFFFF);
        checks++; if (n_upd != 1) begin errors++; $display("FAIL ones_update: got %0d want 1", n_upd); end
        checks++; if (memory !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL ones_memory: got %h want ffffffffffff", memory); end
    endtask

    task automatic test_saturation();
        int total_ferr;
        total_ferr = 0;
        for (int f = 0; f < 260; f++) begin
            send_bits(64'h5, 3);
            total_ferr += n_ferr;
        end
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
        checks++; if (total_ferr != 260) begin errors++; $display("FAIL sat_pulses: got %0d want 260", total_ferr); end
        checks++; if (memory !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL sat_memory: got %h want ffffffffffff", memory); end
    endtask

`ifdef SPI2MEM_CRC8_EN
    task automatic test_crc();
        send_bits({8'h00, 48'h000000000001, 8'h07}, FLEN);
        checks++; if (n_upd != 1) begin errors++; $display("FAIL crc_good_update: got %0d want 1", n_upd); end
        checks++; if (memory !== 48'h000000000001) begin errors++; $display("FAIL crc_good_memory: got %h want 1", memory); end
        send_bits({8'h00, 48'h000000000001, 8'h06}, FLEN);
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL crc_bad_frame_err: got %0d want 1", n_ferr); end
        checks++; if (n_upd != 0) begin errors++; $display("FAIL crc_bad_update: got %0d want 0", n_upd); end
        checks++; if (memory !== 48'h000000000001) begin errors++; $display("FAIL crc_bad_memory: got %h want 1", memory); end
    endtask
`endif

    initial begin
        test_reset();
        test_valid_frame();
        test_short_long();
        test_no_clock();
        test_midframe_reset();
        test_saturation();
`ifdef SPI2MEM_CRC8_EN
        test_crc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
